// File: rtl/flash_stream_pkg.sv
// Shared types and defaults for the flash sample streamer.
package flash_stream_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } rd_state_t;

   localparam int DEF_START_ADDR = 0;
   localparam int DEF_END_ADDR   = 'h7FFFF;

   function automatic int lanes(input int word_w, input int sample_w);
      return word_w / sample_w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Prefetch FIFO: head word visible combinationally, one-cycle push/pop, registered count and flags.
// Push is refused when full unless a pop happens in the same cycle; flush empties it in one cycle.
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   assign do_push = push_i && (!full_q || pop_i);
   assign do_pop  = pop_i && !empty_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign empty_o    = empty_q;

endmodule

// File: rtl/flash_sample_streamer.sv
// Prefetches flash words (one read outstanding, address wraps between bounds) and emits one lane per tick.
// Tick to audio strobe is one registered cycle; empty FIFO on a tick raises underrun, flash stalls hold the read.
module flash_sample_streamer
   import flash_stream_pkg::*;
#(
   parameter int SAMPLE_W   = 16,
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 23,
   parameter int START_ADDR = DEF_START_ADDR,
   parameter int END_ADDR   = DEF_END_ADDR,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pause,
   input  logic                reverse,
   input  logic                restart,
   input  logic                sample_tick,
   input  logic                flsh_waitrequest,
   output logic                flsh_read,
   output logic [ADDR_W-1:0]   flsh_address,
   input  logic [WORD_W-1:0]   flsh_readdata,
   input  logic                flsh_readdatavalid,
   output logic [WORD_W/8-1:0] flsh_byteenable,
   output logic                audio_enable,
   output logic [SAMPLE_W-1:0] audio_out,
   output logic                underrun
);

   localparam int LANES  = lanes(WORD_W, SAMPLE_W);
   localparam int LANE_W = $clog2(LANES);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] END_A     = ADDR_W'(END_ADDR);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   rd_state_t           rd_q, rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                dir_q, dir_d;
   logic                drop_q, drop_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [SAMPLE_W-1:0] audio_q, audio_d;
   logic                audio_en_q, audio_en_d;
   logic                underrun_q, underrun_d;

   logic                fifo_push, fifo_pop, fifo_empty;
   logic [WORD_W:0]     fifo_head;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [WORD_W-1:0]   head_word;
   logic                head_rev;
   logic [LANE_W-1:0]   lane_sel;
   logic                accept, tick_go;

   assign accept  = (rd_q == REQ) && !flsh_waitrequest;
   assign tick_go = sample_tick && !pause && !restart;

   always_comb begin
      rd_d      = rd_q;
      addr_d    = addr_q;
      dir_d     = dir_q;
      drop_d    = drop_q;
      fifo_push = 1'b0;
      case (rd_q)
         IDLE: if (fifo_cnt < CNT_W'(FIFO_DEPTH)) rd_d = REQ;
         REQ: begin
            if (accept) begin
               rd_d  = WAIT;
               dir_d = reverse;
               if (reverse) addr_d = (addr_q == START_A) ? END_A : addr_q - ADDR_W'(1);
               else         addr_d = (addr_q == END_A) ? START_A : addr_q + ADDR_W'(1);
            end
         end
         WAIT: begin
            if (flsh_readdatavalid) begin
               rd_d      = IDLE;
               fifo_push = !drop_q;
               drop_d    = 1'b0;
            end
         end
         default: rd_d = IDLE;
      endcase
      if (restart) begin
         addr_d    = reverse ? END_A : START_A;
         fifo_push = 1'b0;
         // A read accepted in the restart cycle still owes a data beat, so it is waited out and dropped.
         if ((rd_q == WAIT && !flsh_readdatavalid) || accept) begin
            rd_d   = WAIT;
            drop_d = 1'b1;
         end else begin
            rd_d   = IDLE;
            drop_d = 1'b0;
         end
      end
   end

   assign head_word = fifo_head[WORD_W-1:0];
   assign head_rev  = fifo_head[WORD_W];
   assign lane_sel  = head_rev ? (LAST_LANE - lane_q) : lane_q;

   always_comb begin
      lane_d     = lane_q;
      audio_d    = audio_q;
      audio_en_d = 1'b0;
      underrun_d = 1'b0;
      fifo_pop   = 1'b0;
      if (restart) begin
         lane_d = '0;
      end else if (tick_go) begin
         if (fifo_empty) begin
            underrun_d = 1'b1;
         end else begin
            audio_d    = head_word[lane_sel*SAMPLE_W +: SAMPLE_W];
            audio_en_d = 1'b1;
            if (lane_q == LAST_LANE) begin
               fifo_pop = 1'b1;
               lane_d   = '0;
            end else begin
               lane_d = lane_q + LANE_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q       <= IDLE;
         addr_q     <= START_A;
         dir_q      <= 1'b0;
         drop_q     <= 1'b0;
         lane_q     <= '0;
         audio_q    <= '0;
         audio_en_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         dir_q      <= dir_d;
         drop_q     <= drop_d;
         lane_q     <= lane_d;
         audio_q    <= audio_d;
         audio_en_q <= audio_en_d;
         underrun_q <= underrun_d;
      end
   end

   sync_fifo #(
      .WIDTH(WORD_W + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush_i   (restart),
      .push_i    (fifo_push),
      .push_dat_i({dir_q, flsh_readdata}),
      .pop_i     (fifo_pop),
      .head_dat_o(fifo_head),
      .count_o   (fifo_cnt),
      .empty_o   (fifo_empty)
   );

   assign flsh_read       = (rd_q == REQ);
   assign flsh_address    = addr_q;
   assign flsh_byteenable = '1;
   assign audio_enable    = audio_en_q;
   assign audio_out       = audio_q;
   assign underrun        = underrun_q;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Bench for flash_sample_streamer: 4-word region (0..3), 1-cycle flash model, sample scoreboard.
module tb_flash_sample_streamer;

   logic        clk = 1'b0;
   logic        reset, pause, reverse, restart, sample_tick;
   logic        flsh_waitrequest, flsh_read, flsh_readdatavalid;
   logic [22:0] flsh_address;
   logic [31:0] flsh_readdata;
   logic [3:0]  flsh_byteenable;
   logic        audio_enable, underrun;
   logic [15:0] audio_out;

   int          n_chk = 0;
   int          n_fail = 0;
   int          n_rdv = 0;
   int          base, base0;
   logic [15:0] exp_q[$];
   logic [22:0] acc_log[$];
   logic        hold_rdv = 1'b0;
   logic        bad_word = 1'b0;
   logic [31:0] mem [0:3];

   always #5 clk = ~clk;

   flash_sample_streamer #(
      .START_ADDR(0),
      .END_ADDR  (3)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .pause             (pause),
      .reverse           (reverse),
      .restart           (restart),
      .sample_tick       (sample_tick),
      .flsh_waitrequest  (flsh_waitrequest),
      .flsh_read         (flsh_read),
      .flsh_address      (flsh_address),
      .flsh_readdata     (flsh_readdata),
      .flsh_readdatavalid(flsh_readdatavalid),
      .flsh_byteenable   (flsh_byteenable),
      .audio_enable      (audio_enable),
      .audio_out         (audio_out),
      .underrun          (underrun)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w, input logic rev);
      for (int i = 0; i < 2; i++) begin
         int lane;
         lane = rev ? 1 - i : i;
         exp_q.push_back(w[lane*16 +: 16]);
      end
   endtask

   task automatic tick(input logic p, input logic exp_ur);
      sample_tick = 1'b1;
      pause       = p;
      cycles(1);
      sample_tick = 1'b0;
      pause       = 1'b0;
      chk(exp_ur ? "tick_underrun" : "tick_no_underrun", underrun, exp_ur);
   endtask

   // Flash: accept seen mid-cycle, data returned in the following cycle unless held.
   initial begin : flash_model
      logic        pend;
      logic [22:0] pend_addr;
      pend = 1'b0;
      pend_addr = '0;
      flsh_readdatavalid = 1'b0;
      flsh_readdata = '0;
      forever begin
         @(negedge clk);
         if (flsh_read && !flsh_waitrequest && !reset) begin
            pend = 1'b1;
            pend_addr = flsh_address;
            acc_log.push_back(flsh_address);
         end
         @(posedge clk);
         #1;
         flsh_readdatavalid = 1'b0;
         if (pend && !hold_rdv) begin
            flsh_readdatavalid = 1'b1;
            flsh_readdata = bad_word ? 32'hDEAD_BEEF : mem[pend_addr[1:0]];
            pend = 1'b0;
            n_rdv++;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && audio_enable) begin
         if (exp_q.size() == 0) chk("sb_unexpected_enable", audio_enable, 1'b0);
         else                   chk("sample", audio_out, exp_q.pop_front());
      end
   end

   initial begin
      reset = 1'b1; pause = 1'b0; reverse = 1'b0; restart = 1'b0; sample_tick = 1'b0;
      flsh_waitrequest = 1'b1;
      mem[0] = 32'hBBBB_AAAA; mem[1] = 32'hDDDD_CCCC;
      mem[2] = 32'h2222_1111; mem[3] = 32'h4444_3333;
      cycles(3);
      chk("rst_read", flsh_read, 0);
      chk("rst_addr", flsh_address, 0);
      chk("rst_enable", audio_enable, 0);
      chk("rst_audio", audio_out, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_byteen", flsh_byteenable, 4'hF);
      reset = 1'b0;
      cycles(3);

      // Stalled flash: read and address hold, ticks underrun unless paused.
      for (int i = 0; i < 5; i++) begin
         chk("wr_read_held", flsh_read, 1);
         chk("wr_addr_held", flsh_address, 0);
         cycles(1);
      end
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      chk("wr_no_accept", acc_log.size(), 0);
      flsh_waitrequest = 1'b0;
      cycles(1);
      chk("wr_addr_step", flsh_address, 1);
      chk("wr_one_accept", acc_log.size(), 1);
      cycles(1);
      flsh_waitrequest = 1'b1;
      cycles(3);
      chk("wr_no_dup_push", dut.fifo_cnt, 1);
      chk("wr_one_rdv", n_rdv, 1);
      chk("wr_still_one_accept", acc_log.size(), 1);
      push_word(mem[0], 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      flsh_waitrequest = 1'b0;
      cycles(40);

      // Forward fill, single refill after one word drains, then full drain with wrap.
      base = acc_log.size();
      exp_q.delete();
      restart = 1'b1;
      cycles(1);
      restart = 1'b0;
      cycles(40);
      chk("fill_reads", acc_log.size() - base, 4);
      for (int i = 0; i < 4; i++) chk("fill_addr", acc_log[base+i], i);
      chk("fill_read_low", flsh_read, 0);
      chk("fill_count", dut.fifo_cnt, 4);
      push_word(mem[0], 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      cycles(10);
      chk("drain_one_read", acc_log.size() - base, 5);
      chk("drain_wrap_addr", acc_log[base+4], 0);
      push_word(mem[1], 1'b0); push_word(mem[2], 1'b0);
      push_word(mem[3], 1'b0); push_word(mem[0], 1'b0);
      repeat (8) tick(1'b0, 1'b0);
      cycles(40);

      // Reverse playback from END with wrap back to END.
      reverse = 1'b1;
      base = acc_log.size();
      exp_q.delete();
      restart = 1'b1;
      cycles(1);
      restart = 1'b0;
      cycles(40);
      chk("rev_reads", acc_log.size() - base, 4);
      for (int i = 0; i < 4; i++) chk("rev_addr", acc_log[base+i], 3 - i);
      push_word(mem[3], 1'b1); push_word(mem[2], 1'b1);
      push_word(mem[1], 1'b1); push_word(mem[0], 1'b1);
      repeat (8) tick(1'b0, 1'b0);
      cycles(10);
      chk("rev_wrap_addr", acc_log[base+4], 3);
      cycles(30);

      // Restart beats a same-cycle tick; then restart while a read is outstanding.
      reverse = 1'b0;
      hold_rdv = 1'b1;
      exp_q.delete();
      base0 = acc_log.size();
      restart = 1'b1;
      sample_tick = 1'b1;
      cycles(1);
      restart = 1'b0;
      sample_tick = 1'b0;
      chk("rst_tick_no_underrun", underrun, 0);
      chk("rst_tick_no_enable", audio_enable, 0);
      cycles(5);
      chk("rw_one_pending", acc_log.size() - base0, 1);
      bad_word = 1'b1;
      base = acc_log.size();
      restart = 1'b1;
      cycles(1);
      restart = 1'b0;
      hold_rdv = 1'b0;
      cycles(2);
      bad_word = 1'b0;
      cycles(30);
      chk("rw_reads", acc_log.size() - base, 4);
      chk("rw_first_addr", acc_log[base], 0);
      chk("rw_count", dut.fifo_cnt, 4);
      push_word(mem[0], 1'b0);
      push_word(mem[1], 1'b0);
      repeat (4) tick(1'b0, 1'b0);
      cycles(3);
      chk("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
